rom_read_datapath: RTL and testbench



---
 rtl/rom_read_datapath.sv | 131 +++++++++++++
 tb/tb_rom_read_datapath.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_datapath.sv
// Data-phase stage behind the ROM response generator: drives the ROM macro,
// waits the access latency and returns lane-formatted data with a one-word last-read buffer.
//
// state  | meaning
// IDLE   | no transfer in flight, hready_data high, hrdata holds last value
// ROM_EN | rom_cen low for one cycle, ROM sampling rom_addr
// WAIT   | counting ROM access latency, hready_data low
// DONE   | data phase complete this cycle, may accept the next request
module rom_read_datapath #(
  parameter int ADDR_W   = 16,
  parameter int ROM_WAIT = 1,
  parameter int BUF_EN   = 1
) (
  input  logic              hclk,
  input  logic              n_hreset,
  input  logic              cen_in,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [2:0]        hsize,
  input  logic              inv,
  output logic              rom_cen,
  output logic [ADDR_W-3:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  output logic [31:0]       hrdata,
  output logic              hready_data
);

  localparam int WA_W = ADDR_W - 2;
  localparam logic [2:0] WAIT_TC = 3'(ROM_WAIT);

  generate
    if (ROM_WAIT < 1 || ROM_WAIT > 7) begin : g_bad_rom_wait
      $error("rom_read_datapath: ROM_WAIT must be in 1..7");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROM_EN, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic [WA_W-1:0]   tag;
  logic [31:0]       buf_data;
  logic              tag_valid_q;
  logic              tag_valid;
  logic              fill_poison;
  logic [1:0]        off_q;
  logic [2:0]        size_q;
  logic              accept;
  logic              hit;
  logic              cnt_done;

  function automatic logic [31:0] lane_fmt(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  size);
    logic [31:0] r;
    r = '0;
    case (size)
      3'b000:  r[{off, 3'b000} +: 8]     = word[{off, 3'b000} +: 8];
      3'b001:  r[{off[1], 4'b0000} +: 16] = word[{off[1], 4'b0000} +: 16];
      default: r = word;
    endcase
    return r;
  endfunction

  assign tag_valid = (BUF_EN != 0) ? tag_valid_q : 1'b0;
  assign accept    = ((state == IDLE) || (state == DONE)) && !cen_in;
  assign hit       = accept && tag_valid && !inv && (haddr[ADDR_W-1:2] == tag);
  assign cnt_done  = (state == WAIT) && (cnt == WAIT_TC);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = hit ? DONE : ROM_EN;
        else        state_nxt = IDLE;
      end
      ROM_EN:  state_nxt = WAIT;
      WAIT:    if (cnt_done) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge n_hreset) begin
    if (!n_hreset) begin
      state       <= IDLE;
      rom_cen     <= 1'b1;
      hready_data <= 1'b1;
      rom_addr    <= '0;
      hrdata      <= '0;
      cnt         <= '0;
      off_q       <= '0;
      size_q      <= '0;
      fill_poison <= 1'b0;
    end else begin
      state       <= state_nxt;
      rom_cen     <= (state_nxt != ROM_EN);
      hready_data <= (state_nxt == IDLE) || (state_nxt == DONE);

      if (accept) begin
        off_q       <= haddr[1:0];
        size_q      <= hsize;
        fill_poison <= 1'b0;
        if (!hit) rom_addr <= haddr[ADDR_W-1:2];
      end else if (((state == ROM_EN) || (state == WAIT)) && inv) begin
        // invalidate raced with an in-flight fill: return the data but do not cache it
        fill_poison <= 1'b1;
      end

      if (hit)           hrdata <= lane_fmt(buf_data, haddr[1:0], hsize);
      else if (cnt_done) hrdata <= lane_fmt(rom_rdata, off_q, size_q);

      if (state == ROM_EN)    cnt <= 3'd1;
      else if (state == WAIT) cnt <= cnt + 3'd1;
    end
  end

  always_ff @(posedge hclk or negedge n_hreset) begin
    if (!n_hreset) begin
      tag_valid_q <= 1'b0;
      tag         <= '0;
      buf_data    <= '0;
    end else begin
      if (cnt_done) begin
        buf_data <= rom_rdata;
        tag      <= rom_addr;
      end
      if (inv)                           tag_valid_q <= 1'b0;
      else if (cnt_done && !fill_poison) tag_valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_read_datapath.sv
// Bench for rom_read_datapath: two instances (ROM_WAIT=1 and 3) driven one at a time,
// checked against a transaction-level model of latency, buffer hits and lane formatting.
module tb_rom_read_datapath;

  logic        hclk = 1'b0;
  logic        n_hreset;
  logic        cen_in      [2];
  logic [15:0] haddr       [2];
  logic [2:0]  hsize       [2];
  logic        inv         [2];
  logic        rom_cen     [2];
  logic [13:0] rom_addr    [2];
  logic [31:0] rom_rdata   [2] = '{32'h0BAD0BAD, 32'h0BAD0BAD};
  logic [31:0] hrdata      [2];
  logic        hready_data [2];

  int          tests = 0;
  int          fails = 0;
  logic [31:0] key;
  bit          mvalid [2];
  logic [13:0] mtag   [2];

  bit          pend [2] = '{1'b0, 1'b0};
  int          rem  [2];
  logic [13:0] ra   [2];

  always #5 hclk = ~hclk;

  rom_read_datapath #(.ADDR_W(16), .ROM_WAIT(1), .BUF_EN(1)) dut_w1 (
    .hclk(hclk), .n_hreset(n_hreset), .cen_in(cen_in[0]), .haddr(haddr[0]),
    .hsize(hsize[0]), .inv(inv[0]), .rom_cen(rom_cen[0]), .rom_addr(rom_addr[0]),
    .rom_rdata(rom_rdata[0]), .hrdata(hrdata[0]), .hready_data(hready_data[0]));

  rom_read_datapath #(.ADDR_W(16), .ROM_WAIT(3), .BUF_EN(1)) dut_w3 (
    .hclk(hclk), .n_hreset(n_hreset), .cen_in(cen_in[1]), .haddr(haddr[1]),
    .hsize(hsize[1]), .inv(inv[1]), .rom_cen(rom_cen[1]), .rom_addr(rom_addr[1]),
    .rom_rdata(rom_rdata[1]), .hrdata(hrdata[1]), .hready_data(hready_data[1]));

  function automatic int rwait(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] rom_val(logic [13:0] w);
    if (w == 14'h0004) return 32'hA1B2C3D4;
    return (32'(w) * 32'h9E3779B1) ^ key;
  endfunction

  // expected lanes: n = bytes in transfer, aligned start lane, mask from plain arithmetic
  function automatic logic [31:0] exp_fmt(logic [31:0] w, logic [1:0] off, logic [2:0] sz);
    int n, lo;
    logic [63:0] mask;
    n    = 1 << sz;
    lo   = (int'(off) / n) * n;
    mask = ((64'd1 << (8 * n)) - 64'd1) << (8 * lo);
    return w & mask[31:0];
  endfunction

  // ROM macro model: data valid only in the cycle ROM_WAIT cycles after the rom_cen-low cycle
  always @(negedge hclk) begin
    for (int i = 0; i < 2; i++) begin
      rom_rdata[i] = 32'h0BAD0BAD;
      if (!n_hreset) pend[i] = 1'b0;
      if (pend[i]) begin
        rem[i] = rem[i] - 1;
        if (rem[i] == 0) begin
          rom_rdata[i] = rom_val(ra[i]);
          pend[i] = 1'b0;
        end
      end
      if (!rom_cen[i] && n_hreset) begin
        pend[i] = 1'b1;
        rem[i]  = rwait(i);
        ra[i]   = rom_addr[i];
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge of the completing cycle so the next
  // call issues its address phase in that same cycle (back-to-back).
  task automatic do_read(int d, logic [15:0] a, logic [2:0] sz, int inv_cyc, string tag);
    logic [13:0] w;
    bit          hit, done;
    int          waits, pulses, k;
    logic [31:0] exp_d;
    w     = a[15:2];
    hit   = mvalid[d] && (mtag[d] == w) && (inv_cyc != 0);
    exp_d = exp_fmt(rom_val(w), a[1:0], sz);
    cen_in[d] = 1'b0; haddr[d] = a; hsize[d] = sz; inv[d] = (inv_cyc == 0);
    waits = 0; pulses = 0; done = 1'b0; k = 0;
    while (!done && k < 30) begin
      @(negedge hclk);
      k++;
      if (!rom_cen[d]) begin
        pulses++;
        chk({tag, "_romaddr"}, 32'(rom_addr[d]), 32'(w));
      end
      if (hready_data[d]) done = 1'b1;
      else                waits++;
      cen_in[d] = 1'b1;
      inv[d]    = (inv_cyc == k);
    end
    chk({tag, "_waits"},  32'(waits),  hit ? 32'd0 : 32'(rwait(d) + 1));
    chk({tag, "_pulses"}, 32'(pulses), hit ? 32'd0 : 32'd1);
    chk({tag, "_hrdata"}, hrdata[d], exp_d);
    if (!hit) begin
      mvalid[d] = !(inv_cyc >= 1 && inv_cyc <= rwait(d) + 1);
      mtag[d]   = w;
    end
  endtask

  task automatic idle(int d, int n, bit inv_pulse);
    cen_in[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      inv[d] = inv_pulse && (i == 0);
      @(negedge hclk);
    end
    inv[d] = 1'b0;
    if (inv_pulse && n > 0) mvalid[d] = 1'b0;
  endtask

  task automatic reset_in_wait(int d, logic [15:0] a);
    cen_in[d] = 1'b0; haddr[d] = a; hsize[d] = 3'b010; inv[d] = 1'b0;
    @(negedge hclk);
    cen_in[d] = 1'b1;
    @(negedge hclk);
    chk("rst_pre_ready", 32'(hready_data[d]), 32'd0);
    n_hreset = 1'b0;
    #1;
    chk("rst_romcen",  32'(rom_cen[d]),     32'd1);
    chk("rst_ready",   32'(hready_data[d]), 32'd1);
    chk("rst_hrdata",  hrdata[d],           32'd0);
    chk("rst_romaddr", 32'(rom_addr[d]),    32'd0);
    mvalid[0] = 1'b0;
    mvalid[1] = 1'b0;
    repeat (2) @(negedge hclk);
    n_hreset = 1'b1;
    @(negedge hclk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] pool [6];
    logic [15:0] a;
    int          r, ic;
    pool = '{14'h0004, 14'h0005, 14'h1234, 14'h3FFF, 14'h0000, 14'h0040};
    key = $urandom;
    n_hreset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cen_in[i] = 1'b1; haddr[i] = '0; hsize[i] = 3'b010; inv[i] = 1'b0;
      mvalid[i] = 1'b0; mtag[i] = '0;
    end
    repeat (2) @(negedge hclk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_romcen",  32'(rom_cen[i]),     32'd1);
      chk("reset_ready",   32'(hready_data[i]), 32'd1);
      chk("reset_hrdata",  hrdata[i],           32'd0);
      chk("reset_romaddr", 32'(rom_addr[i]),    32'd0);
    end
    n_hreset = 1'b1;
    @(negedge hclk);

    do_read(0, 16'h0010, 3'b010, -1, "w10_miss");
    do_read(0, 16'h0010, 3'b010, -1, "w10_hit");
    do_read(0, 16'h0013, 3'b000, -1, "b13_hit");
    do_read(0, 16'h0012, 3'b001, -1, "h12_hit");
    idle(0, 2, 1'b0);

    do_read(1, 16'h0100, 3'b010, -1, "w100");
    do_read(1, 16'h0104, 3'b010, -1, "w104");
    idle(1, 1, 1'b0);
    do_read(1, 16'h0020, 3'b010, 2,  "w20_inv_wait");
    do_read(1, 16'h0020, 3'b010, -1, "w20_refill");
    do_read(1, 16'h0020, 3'b010, 0,  "w20_inv_accept");
    idle(1, 2, 1'b1);
    do_read(1, 16'h0020, 3'b001, -1, "w20_after_idle_inv");
    idle(1, 1, 1'b0);

    do_read(0, 16'h0040, 3'b010, -1, "w40_fill");
    idle(0, 1, 1'b0);
    reset_in_wait(0, 16'h0080);
    do_read(0, 16'h0040, 3'b010, -1, "w40_after_reset");

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        a  = {pool[$urandom_range(0, 5)], 2'($urandom_range(0, 3))};
        r  = $urandom_range(0, 9);
        ic = (r == 0) ? 0 : (r == 1) ? 2 : -1;
        do_read(d, a, 3'($urandom_range(0, 2)), ic, "rand");
        if ($urandom_range(0, 2) == 0)
          idle(d, $urandom_range(1, 2), $urandom_range(0, 7) == 0);
      end
      idle(d, 1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
